// File: rtl/fb_pkg.sv
// Shared types and widths for the framebuffer write path.
//   COORD_W / COLOR_W / PIX_W : pixel field widths (x, y, colour)
//   arb_state_t               : write arbiter states
//   pix_t / make_pix          : packed pixel payload and its constructor
package fb_pkg;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned COLOR_W = 1;
    localparam int unsigned PIX_W   = 2 * COORD_W + COLOR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pix_t;

    function automatic pix_t make_pix(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y,
                                      input logic [COLOR_W-1:0] color);
        pix_t p;
        p.x     = x;
        p.y     = y;
        p.color = color;
        return p;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO for buffered pixel writes.
//   clk, rst_n     : clock, async active-low reset (flushes pointers/count)
//   push, wdata    : write request and data; caller must not push when full
//                    unless popping in the same cycle
//   pop            : removes the head entry; caller must not pop when empty
//   head_c         : current head entry (valid when !empty_c)
//   full_c,empty_c : occupancy flags
//   count          : number of stored entries
module pix_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    assign head_c  = mem[rptr];
    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == CNT_W'(0));

    // Storage array: no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates draw_engine pixel writes and a full-screen clear sweep onto the
// single framebuffer write port (valid/ready, stall tolerant).
//   clk, rst_n                          : clock, async active-low reset
//   pix_valid/pix_x/pix_y/pix_color     : pixel write request
//   pix_ready                           : pixel accepted this cycle when high
//   clear_req                           : rising edge schedules a clear sweep
//   ovf_clr                             : clears the sticky overflow flag
//   fb_we/fb_x/fb_y/fb_data, fb_ready   : framebuffer write port
//   stall                               : hold off new shape/spray starts
//   clear_busy / clear_done             : clear pending-or-running / end pulse
//   overflow                            : sticky, a pixel was dropped
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLR_X_MAX  = 127,
    parameter int unsigned CLR_Y_MAX  = 127
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_color,
    output logic               pix_ready,
    input  logic               clear_req,
    input  logic               ovf_clr,
    output logic               fb_we,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic               fb_data,
    input  logic               fb_ready,
    output logic               stall,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    arb_state_t       state_q, state_nxt;
    pix_t             out_q, out_nxt;
    logic             we_nxt;
    logic             done_nxt;
    logic             clr_req_q;

    logic             xfer_c, out_free_c, clr_edge_c, accept_c;
    logic             push_c, pop_c;
    logic [PIX_W-1:0] head_c;
    logic             fifo_full_c, fifo_empty_c;
    logic [CNT_W-1:0] fifo_count;

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wdata   (make_pix(pix_x, pix_y, pix_color)),
        .pop     (pop_c),
        .head_c  (head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count   (fifo_count)
    );

    // Handshake and capacity decode.
    assign xfer_c     = fb_we && fb_ready;
    assign out_free_c = !fb_we || xfer_c;
    assign clr_edge_c = clear_req && !clr_req_q;
    assign pix_ready  = (state_q == ST_IDLE) && !(fifo_full_c && fb_we && !xfer_c);
    assign accept_c   = pix_valid && pix_ready;
    // Bypass the FIFO when it is empty and the output register can load now.
    assign push_c     = accept_c && !(fifo_empty_c && out_free_c);
    assign pop_c      = (state_q != ST_CLEAR) && out_free_c && !fifo_empty_c;
    assign stall      = clear_busy || (fifo_count >= CNT_W'(FIFO_DEPTH - 1));

    assign fb_x    = out_q.x;
    assign fb_y    = out_q.y;
    assign fb_data = out_q.color;

    // Next state and next output register contents.
    always_comb begin
        state_nxt = state_q;
        we_nxt    = fb_we;
        out_nxt   = out_q;
        done_nxt  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DRAIN: begin
                if (out_free_c) begin
                    if (!fifo_empty_c) begin
                        we_nxt  = 1'b1;
                        out_nxt = pix_t'(head_c);
                    end else if (accept_c) begin
                        we_nxt  = 1'b1;
                        out_nxt = make_pix(pix_x, pix_y, pix_color);
                    end else begin
                        we_nxt  = 1'b0;
                    end
                end
                if (state_q == ST_IDLE) begin
                    if (clr_edge_c) begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (fifo_empty_c && out_free_c) begin
                    // All pixels written: start the sweep at (0,0).
                    state_nxt = ST_CLEAR;
                    we_nxt    = 1'b1;
                    out_nxt   = make_pix(COORD_W'(0), COORD_W'(0), COLOR_W'(0));
                end
            end
            ST_CLEAR: begin
                if (xfer_c) begin
                    if (out_q.x == COORD_W'(CLR_X_MAX) && out_q.y == COORD_W'(CLR_Y_MAX)) begin
                        state_nxt = ST_IDLE;
                        we_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                    end else if (out_q.x < COORD_W'(CLR_X_MAX)) begin
                        out_nxt.x = out_q.x + COORD_W'(1);
                    end else begin
                        out_nxt.x = COORD_W'(0);
                        out_nxt.y = out_q.y + COORD_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                we_nxt    = 1'b0;
            end
        endcase
    end

    // State, output register and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fb_we      <= 1'b0;
            out_q      <= '0;
            clear_done <= 1'b0;
            clear_busy <= 1'b0;
            overflow   <= 1'b0;
            clr_req_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            fb_we      <= we_nxt;
            out_q      <= out_nxt;
            clear_done <= done_nxt;
            clear_busy <= (state_nxt != ST_IDLE);
            clr_req_q  <= clear_req;
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (pix_valid && !pix_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios followed by
// random traffic, all compared cycle by cycle against a queue-based model.
module tb_fb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int XM    = 3;
    localparam int YM    = 1;
    localparam int NCLR  = (XM + 1) * (YM + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_x = '0;
    logic [7:0] pix_y = '0;
    logic       pix_color = 1'b0;
    logic       pix_ready;
    logic       clear_req = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       fb_we;
    logic [7:0] fb_x;
    logic [7:0] fb_y;
    logic       fb_data;
    logic       fb_ready = 1'b0;
    logic       stall;
    logic       clear_busy;
    logic       clear_done;
    logic       overflow;

    fb_write_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .CLR_X_MAX  (XM),
        .CLR_Y_MAX  (YM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color),
        .pix_ready  (pix_ready),
        .clear_req  (clear_req),
        .ovf_clr    (ovf_clr),
        .fb_we      (fb_we),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .fb_data    (fb_data),
        .fb_ready   (fb_ready),
        .stall      (stall),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: everything held inside the arbiter, oldest first ({x,y,c}).
    bit [16:0] mq[$];
    int        m_mode;   // 0 idle, 1 waiting for pixels to drain, 2 clearing
    int        m_k;      // index of the clear write currently offered
    bit        m_ovf, m_done, m_prev;

    int obs_xfer = 0;
    int obs_clr  = 0;
    int obs_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 0;
        m_k    = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_prev = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic cyc(input bit pv, input bit [7:0] px, input bit [7:0] py,
                       input bit pc, input bit fr, input bit cr, input bit oc);
        bit        e_we, e_busy, e_stall, e_rdy, xf;
        bit [7:0]  ex, ey;
        bit        ec;
        int        fcnt;
        pix_valid = pv; pix_x = px; pix_y = py; pix_color = pc;
        fb_ready = fr; clear_req = cr; ovf_clr = oc;
        @(negedge clk);
        ex = 0; ey = 0; ec = 0;
        e_busy = (m_mode != 0);
        if (m_mode == 2) begin
            e_we = 1'b1;
            ex = 8'(m_k % (XM + 1));
            ey = 8'(m_k / (XM + 1));
        end else begin
            e_we = (mq.size() > 0);
            if (e_we) {ex, ey, ec} = mq[0];
        end
        fcnt    = (mq.size() > 0 && m_mode != 2) ? mq.size() - 1 : 0;
        e_stall = e_busy || (fcnt >= DEPTH - 1);
        e_rdy   = (m_mode == 0) && ((mq.size() < DEPTH + 1) || (e_we && fr));
        chk("fb_we", fb_we, e_we);
        if (e_we) begin
            chk("fb_x", fb_x, ex);
            chk("fb_y", fb_y, ey);
            chk("fb_data", fb_data, ec);
        end
        chk("pix_ready", pix_ready, e_rdy);
        chk("stall", stall, e_stall);
        chk("clear_busy", clear_busy, e_busy);
        chk("clear_done", clear_done, m_done);
        chk("overflow", overflow, m_ovf);
        if (fb_we && fb_ready) obs_xfer++;
        if (fb_we && fb_ready && clear_busy) obs_clr++;
        if (clear_done) obs_done++;
        // Model update for the coming edge.
        xf     = e_we && fr;
        m_done = 1'b0;
        if (m_mode != 2) begin
            if (xf) void'(mq.pop_front());
            if (pv && e_rdy) mq.push_back({px, py, pc});
        end
        case (m_mode)
            0: if (cr && !m_prev) m_mode = 1;
            1: if (mq.size() == 0) begin m_mode = 2; m_k = 0; end
            default: if (xf) begin
                if (m_k == NCLR - 1) begin m_mode = 0; m_done = 1'b1; end
                else m_k++;
            end
        endcase
        if (oc) m_ovf = 1'b0;
        else if (pv && !e_rdy) m_ovf = 1'b1;
        m_prev = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit fr);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, fr, 0, 0);
    endtask

    int base;

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_fb_we", fb_we, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values, then single pixel with latency 1, held one cycle.
        idle_cycles(2, 1);
        cyc(1, 10, 20, 1, 1, 0, 0);
        chk("single_we", fb_we, 1'b1);
        idle_cycles(3, 1);

        // Fill to capacity with a stalled port, sixth pixel dropped.
        for (int i = 1; i <= 6; i++) cyc(1, 8'(i), 0, 1, 0, 0, 0);
        chk("ovf_set", overflow, 1'b1);
        base = obs_xfer;
        idle_cycles(8, 1);
        chk("ovf_writes", obs_xfer - base, 5);
        cyc(0, 0, 0, 0, 1, 0, 1);
        idle_cycles(1, 1);

        // Toggling fb_ready with 4 pixels.
        base = obs_xfer;
        for (int i = 0; i < 4; i++) cyc(1, 8'(40 + i), 8'(i), 1, i[0] == 1'b0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, i[0] == 1'b0, 0, 0);
        chk("toggle_writes", obs_xfer - base, 4);

        // Plain clear sweep.
        base = obs_clr;
        cyc(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 40 && m_mode != 0; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        idle_cycles(2, 1);
        chk("clear_writes", obs_clr - base, NCLR);
        chk("clear_done_cnt", obs_done, 1);
        chk("clear_end_busy", clear_busy, 1'b0);

        // Pixels queued before a clear, a pixel during drain is dropped.
        cyc(1, 30, 5, 1, 0, 0, 0);
        cyc(1, 31, 6, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 99, 99, 1, 0, 0, 0);
        chk("drain_ovf", overflow, 1'b1);
        for (int i = 0; i < 40 && m_mode != 0; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        idle_cycles(2, 1);
        chk("drain_done_cnt", obs_done, 2);
        cyc(0, 0, 0, 0, 1, 0, 1);

        // Reset in the middle of a clear sweep.
        base = obs_clr;
        cyc(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 20 && obs_clr < base + 3; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        chk("pre_rst_clears", obs_clr - base, 3);
        rst_n = 1'b0;
        clear_req = 1'b0;
        #1;
        chk("arst_fb_we", fb_we, 1'b0);
        chk("arst_busy", clear_busy, 1'b0);
        chk("arst_stall", stall, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = obs_xfer;
        cyc(1, 77, 88, 1, 1, 0, 0);
        chk("post_rst_latency", fb_we, 1'b1);
        idle_cycles(4, 1);
        chk("post_rst_writes", obs_xfer - base, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0,
                $urandom_range(0, 30) == 0);
        end
        for (int i = 0; i < 60 && (m_mode != 0 || mq.size() != 0); i++) cyc(0, 0, 0, 0, 1, 0, 0);
        idle_cycles(2, 1);
        chk("final_idle_we", fb_we, 1'b0);
        chk("final_idle_busy", clear_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
